// File: rtl/md4_crack_sequencer.sv
// Job controller for a single md4 core: streams candidates into the core byte-serially,
// collects the 16-byte digest and compares it against the job target.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no job; waiting for job_start
// WAIT_CAND | ready for the next candidate once the core is idle
// START     | one-cycle core_start pulse, timeout timer loaded
// FEED      | presenting candidate bytes to the core
// COLLECT   | capturing the 16 digest bytes from the core
// COMPARE   | digest vs target, update counters, pick next state
// END       | one-cycle done pulse
module md4_crack_sequencer #(
  parameter int MAX_LEN       = 16,
  parameter int LEN_W         = 7,
  parameter int STOP_ON_MATCH = 1,
  parameter int TIMEOUT       = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   job_start,
  input  logic [127:0]           target_digest,
  input  logic                   cand_valid,
  output logic                   cand_ready,
  input  logic [LEN_W-1:0]       cand_len,
  input  logic [8*MAX_LEN-1:0]   cand_data,
  input  logic                   cand_last,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic [31:0]            found_index,
  output logic [31:0]            tested_count,
  output logic                   timeout_err,
  output logic                   core_start,
  output logic [63:0]            core_size,
  output logic [7:0]             core_byte,
  output logic                   core_in_avail,
  input  logic                   core_in_read,
  input  logic                   core_busy,
  input  logic                   core_done,
  input  logic [7:0]             core_out_byte,
  output logic                   core_out_ready,
  input  logic                   core_out_write
);

  localparam int SEL_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_CAND, S_START, S_FEED, S_COLLECT, S_COMPARE, S_END
  } state_t;

  state_t               state, state_nxt;
  logic [127:0]         target_q, dig_q;
  logic [8*MAX_LEN-1:0] cand_q;
  logic [LEN_W-1:0]     len_q, feed_idx, len_sat;
  logic                 last_q;
  logic [4:0]           dig_idx;
  logic [TMR_W-1:0]     tmr;
  logic                 tmo, accept, consume, store, dig_match;

  assign len_sat   = (cand_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cand_len;
  assign dig_match = (dig_q == target_q);
  assign tmo       = (tmr == '0);
  assign core_size = 64'(len_q);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    busy           = (state != S_IDLE);
    done           = 1'b0;
    cand_ready     = 1'b0;
    core_start     = 1'b0;
    core_in_avail  = 1'b0;
    core_byte      = 8'd0;
    core_out_ready = 1'b0;
    accept         = 1'b0;
    consume        = 1'b0;
    store          = 1'b0;
    case (state)
      S_IDLE: if (job_start) state_nxt = S_WAIT_CAND;
      S_WAIT_CAND: begin
        // a core still raising DONE is about to self-reset; hold off one more cycle
        cand_ready = !core_busy && !core_done;
        if (cand_valid && cand_ready) begin
          accept    = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        state_nxt  = (len_q == '0) ? S_COLLECT : S_FEED;
      end
      S_FEED: begin
        core_in_avail = (feed_idx < len_q);
        if (core_in_avail) core_byte = cand_q[8*feed_idx[SEL_W-1:0] +: 8];
        consume = core_in_avail && core_in_read;
        if (tmo)                    state_nxt = S_END;
        else if (feed_idx == len_q) state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        core_out_ready = 1'b1;
        store          = core_out_write && (dig_idx != 5'd16);
        if (tmo)                    state_nxt = S_END;
        else if (dig_idx == 5'd16)  state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        if ((dig_match && (STOP_ON_MATCH != 0)) || last_q) state_nxt = S_END;
        else                                              state_nxt = S_WAIT_CAND;
      end
      S_END: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      target_q     <= '0;
      dig_q        <= '0;
      cand_q       <= '0;
      len_q        <= '0;
      last_q       <= 1'b0;
      feed_idx     <= '0;
      dig_idx      <= '0;
      tmr          <= '0;
      found        <= 1'b0;
      found_index  <= '0;
      tested_count <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (state == S_IDLE && job_start) begin
        target_q     <= target_digest;
        found        <= 1'b0;
        found_index  <= '0;
        tested_count <= '0;
        timeout_err  <= 1'b0;
      end
      if (accept) begin
        cand_q <= cand_data;
        len_q  <= len_sat;
        last_q <= cand_last;
      end
      if (state == S_START) begin
        feed_idx <= '0;
        dig_idx  <= '0;
        tmr      <= TMR_W'(TIMEOUT - 1);
      end
      // timer counts down across feed and collect; reaching zero aborts the job
      if (state == S_FEED || state == S_COLLECT) begin
        if (tmo) timeout_err <= 1'b1;
        else     tmr         <= tmr - 1'b1;
      end
      if (consume) feed_idx <= feed_idx + 1'b1;
      if (store) begin
        dig_q[8*dig_idx[3:0] +: 8] <= core_out_byte;
        dig_idx                    <= dig_idx + 1'b1;
      end
      if (state == S_COMPARE) begin
        tested_count <= tested_count + 32'd1;
        if (dig_match && !found) begin
          found       <= 1'b1;
          found_index <= tested_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_md4_crack_sequencer.sv
// Bench for md4_crack_sequencer: behavioural md4 core (real MD4 hash) plus a job-level
// reference model computing expected match/index/count from the candidate list.
module tb_md4_crack_sequencer;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 7;
  localparam int STOP    = 1;
  localparam logic [127:0] MD4_EMPTY = 128'h31d6cfe0d16ae931b73c59d7e0c089c0;
  localparam logic [127:0] MD4_ABC   = 128'ha448017aaf21d8525fc10ae87aa6729d;

  typedef logic [8*MAX_LEN-1:0] cand_t;

  logic clk;
  logic reset, job_start, cand_valid, cand_ready, cand_last;
  logic [127:0] target_digest;
  logic [LEN_W-1:0] cand_len;
  cand_t cand_data;
  logic busy, done, found, timeout_err, core_start;
  logic [31:0] found_index, tested_count;
  logic [63:0] core_size;
  logic [7:0] core_byte, core_out_byte;
  logic core_in_avail, core_in_read, core_busy, core_done, core_out_ready, core_out_write;

  int n_cmp = 0;
  int n_bad = 0;
  cand_t cq_data[$];
  int cq_len[$];
  int starts, dones, ready_after;
  bit job_seen;
  int cm_bytes;
  bit cm_no_output = 0;

  md4_crack_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .STOP_ON_MATCH(STOP), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .job_start(job_start), .target_digest(target_digest),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_len(cand_len),
    .cand_data(cand_data), .cand_last(cand_last), .busy(busy), .done(done),
    .found(found), .found_index(found_index), .tested_count(tested_count),
    .timeout_err(timeout_err), .core_start(core_start), .core_size(core_size),
    .core_byte(core_byte), .core_in_avail(core_in_avail), .core_in_read(core_in_read),
    .core_busy(core_busy), .core_done(core_done), .core_out_byte(core_out_byte),
    .core_out_ready(core_out_ready), .core_out_write(core_out_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] bswap(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
    return r;
  endfunction

  // Single-block MD4; returned digest has its first byte at [7:0].
  function automatic logic [127:0] md4(input cand_t d, input int len);
    logic [7:0]  blk [64];
    logic [31:0] x [16];
    logic [31:0] st [4];
    logic [31:0] f, v, add;
    int s1 [4] = '{3, 7, 11, 19};
    int s2 [4] = '{3, 5, 9, 13};
    int s3 [4] = '{3, 9, 11, 15};
    int k3 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int t, k, s;
    logic [15:0] bits;
    for (int i = 0; i < 64; i++) begin
      blk[i] = 8'd0;
      if (i < len) blk[i] = d[8*i +: 8];
    end
    blk[len] = 8'h80;
    bits = 16'(len * 8);
    blk[56] = bits[7:0];
    blk[57] = bits[15:8];
    for (int i = 0; i < 16; i++) x[i] = {blk[4*i+3], blk[4*i+2], blk[4*i+1], blk[4*i]};
    st[0] = 32'h67452301; st[1] = 32'hefcdab89; st[2] = 32'h98badcfe; st[3] = 32'h10325476;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin
        t = (4 - i % 4) % 4;
        if (r == 0) begin
          f = (st[(t+1)%4] & st[(t+2)%4]) | (~st[(t+1)%4] & st[(t+3)%4]);
          k = i; s = s1[i%4]; add = 32'h0;
        end else if (r == 1) begin
          f = (st[(t+1)%4] & st[(t+2)%4]) | (st[(t+1)%4] & st[(t+3)%4]) | (st[(t+2)%4] & st[(t+3)%4]);
          k = (i % 4) * 4 + i / 4; s = s2[i%4]; add = 32'h5a827999;
        end else begin
          f = st[(t+1)%4] ^ st[(t+2)%4] ^ st[(t+3)%4];
          k = k3[i]; s = s3[i%4]; add = 32'h6ed9eba1;
        end
        v = st[t] + f + x[k] + add;
        st[t] = (v << s) | (v >> (32 - s));
      end
    end
    return {st[3] + 32'h10325476, st[2] + 32'h98badcfe, st[1] + 32'hefcdab89, st[0] + 32'h67452301};
  endfunction

  function automatic cand_t str2cand(input string s);
    cand_t r = '0;
    for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  function automatic void job_ref(input logic [127:0] tgt, output bit f, output int fi,
                                  output int tc, output int nb);
    f = 0; fi = 0; tc = 0; nb = 0;
    foreach (cq_len[i]) begin
      int l;
      l = (cq_len[i] > MAX_LEN) ? MAX_LEN : cq_len[i];
      nb += l;
      tc++;
      if (md4(cq_data[i], l) == tgt) begin
        if (!f) begin f = 1; fi = i; end
        if (STOP != 0) break;
      end
    end
  endfunction

  // Behavioural md4 core: takes bytes with occasional stalls, then writes the real digest.
  initial begin
    int cm_state, cm_size, cm_n, cm_wr;
    cand_t cm_buf;
    logic [127:0] cm_dig;
    core_busy = 0; core_done = 0; core_in_read = 0; core_out_write = 0; core_out_byte = 0;
    cm_state = 0; cm_size = 0; cm_n = 0; cm_wr = 0; cm_buf = '0; cm_dig = '0;
    forever begin
      @(negedge clk);
      core_in_read = 0; core_out_write = 0; core_done = 0;
      if (!reset) begin
        cm_state = 0; core_busy = 0;
      end else begin
        case (cm_state)
          0: if (core_start) begin
            cm_size = int'(core_size); cm_n = 0; cm_buf = '0; core_busy = 1; cm_state = 1;
          end
          1: if (cm_n >= cm_size) begin
            cm_dig = md4(cm_buf, cm_size); cm_wr = 0; cm_state = 2;
          end else if (core_in_avail && $urandom_range(0, 7) != 0) begin
            if (cm_n < MAX_LEN) cm_buf[8*cm_n +: 8] = core_byte;
            cm_n++; cm_bytes++; core_in_read = 1;
          end
          2: if (!cm_no_output && core_out_ready && $urandom_range(0, 7) != 0) begin
            core_out_byte = cm_dig[8*cm_wr +: 8]; core_out_write = 1; cm_wr++;
            if (cm_wr == 16) cm_state = 3;
          end
          default: begin core_done = 1; core_busy = 0; cm_state = 0; end
        endcase
      end
    end
  end

  task automatic run_job(input logic [127:0] tgt, input bit toggle, input int tail);
    int idx, budget, after;
    starts = 0; dones = 0; ready_after = 0; job_seen = 0; cm_bytes = 0;
    idx = 0; budget = 0; after = 0;
    @(negedge clk);
    target_digest = tgt; job_start = 1;
    @(negedge clk);
    job_start = 0;
    while (after < tail && budget < 5000) begin
      if (idx < cq_len.size()) begin
        cand_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        cand_data  = cq_data[idx];
        cand_len   = LEN_W'(cq_len[idx]);
        cand_last  = (idx == cq_len.size() - 1);
      end else cand_valid = 0;
      #1;
      if (core_start) starts++;
      if (done) begin dones++; job_seen = 1; end
      else if (job_seen && cand_ready) ready_after++;
      if (cand_valid && cand_ready) idx++;
      if (job_seen) after++;
      budget++;
      @(negedge clk);
    end
    cand_valid = 0;
  endtask

  task automatic run_abc3(input string tag);
    cq_data.delete(); cq_len.delete();
    cq_data.push_back(str2cand("a"));   cq_len.push_back(1);
    cq_data.push_back(str2cand("ab"));  cq_len.push_back(2);
    cq_data.push_back(str2cand("abc")); cq_len.push_back(3);
    run_job(bswap(MD4_ABC), 0, 10);
    check({tag, "_done_seen"}, job_seen, 1);
    check({tag, "_found"}, found, 1);
    check({tag, "_index"}, found_index, 2);
    check({tag, "_tested"}, tested_count, 3);
    check({tag, "_starts"}, starts, 3);
    check({tag, "_dones"}, dones, 1);
  endtask

  initial begin
    bit rf;
    int rfi, rtc, rnb, n, k, l;
    reset = 0; job_start = 0; target_digest = '0; cand_valid = 0;
    cand_len = '0; cand_data = '0; cand_last = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", {cand_ready, busy, done, found, timeout_err, core_start,
                        core_in_avail, core_out_ready, core_byte}, 0);
    check("reset_cnt", {found_index, tested_count, core_size}, 0);
    @(negedge clk);
    reset = 1;

    // empty password against MD4("")
    cq_data.delete(); cq_len.delete();
    cq_data.push_back('0); cq_len.push_back(0);
    run_job(bswap(MD4_EMPTY), 0, 10);
    check("t1_done_seen", job_seen, 1);
    check("t1_found", found, 1);
    check("t1_index", found_index, 0);
    check("t1_tested", tested_count, 1);
    check("t1_dones", dones, 1);
    check("t1_busy", busy, 0);

    run_abc3("t2");

    // stop on match with candidates still waiting
    cq_data.delete(); cq_len.delete();
    cq_data.push_back(str2cand("x"));   cq_len.push_back(1);
    cq_data.push_back(str2cand("abc")); cq_len.push_back(3);
    cq_data.push_back(str2cand("y"));   cq_len.push_back(1);
    cq_data.push_back(str2cand("z"));   cq_len.push_back(1);
    run_job(bswap(MD4_ABC), 0, 20);
    check("t3_found", found, 1);
    check("t3_index", found_index, 1);
    check("t3_tested", tested_count, 2);
    check("t3_starts", starts, 2);
    check("t3_ready_after_done", ready_after, 0);
    check("t3_dones", dones, 1);

    // no-match job, random data and lengths (some above MAX_LEN), toggling valid
    cq_data.delete(); cq_len.delete();
    for (int i = 0; i < 5; i++) begin
      cq_data.push_back({$urandom, $urandom, $urandom, $urandom});
      cq_len.push_back((i == 0) ? 20 : int'($urandom_range(0, 20)));
    end
    target_digest = {$urandom, $urandom, $urandom, $urandom};
    job_ref(target_digest, rf, rfi, rtc, rnb);
    run_job(target_digest, 1, 10);
    check("t4_found", found, 0);
    check("t4_tested", tested_count, 5);
    check("t4_starts", starts, 5);
    check("t4_dones", dones, 1);
    check("t4_bytes_fed", cm_bytes, rnb);

    // random jobs with a planted match
    for (int j = 0; j < 3; j++) begin
      cq_data.delete(); cq_len.delete();
      n = $urandom_range(3, 6);
      k = $urandom_range(0, n - 1);
      for (int i = 0; i < n; i++) begin
        cq_data.push_back({$urandom, $urandom, $urandom, $urandom});
        cq_len.push_back(int'($urandom_range(1, 20)));
      end
      l = (cq_len[k] > MAX_LEN) ? MAX_LEN : cq_len[k];
      target_digest = md4(cq_data[k], l);
      job_ref(target_digest, rf, rfi, rtc, rnb);
      run_job(target_digest, 1, 10);
      check("rnd_found", found, rf);
      check("rnd_index", found_index, rfi);
      check("rnd_tested", tested_count, rtc);
      check("rnd_starts", starts, rtc);
      check("rnd_bytes_fed", cm_bytes, rnb);
      check("rnd_dones", dones, 1);
    end

    // reset in the middle of FEED
    @(negedge clk);
    target_digest = bswap(MD4_ABC); job_start = 1;
    @(negedge clk);
    job_start = 0; cand_valid = 1; cand_data = str2cand("abcdefghijklmnop");
    cand_len = LEN_W'(16); cand_last = 1;
    k = 0;
    #1;
    while (!core_in_avail && k < 200) begin
      @(negedge clk); #1; k++;
    end
    check("t6_reached_feed", core_in_avail, 1);
    reset = 0; cand_valid = 0;
    @(posedge clk); #1;
    check("t6_reset_ctl", {cand_ready, busy, done, found, timeout_err, core_start,
                           core_in_avail, core_out_ready, core_byte}, 0);
    check("t6_reset_cnt", {found_index, tested_count, core_size}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1;
    run_abc3("t6_rerun");

    // core never writes its digest
    cm_no_output = 1;
    cq_data.delete(); cq_len.delete();
    cq_data.push_back(str2cand("abc")); cq_len.push_back(3);
    run_job(bswap(MD4_ABC), 0, 10);
    check("t5_done_seen", job_seen, 1);
    check("t5_timeout_err", timeout_err, 1);
    check("t5_dones", dones, 1);
    check("t5_busy", busy, 0);
    check("t5_found", found, 0);
    check("t5_tested", tested_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
